sequence_generator_io: RTL and testbench
========================================

Name: sequence_generator_io

Overview:
Serial bit-pattern transmitter: the driving end of the single-bit serial stream consumed by the team's sequence-detector FSMs. It captures a pattern of up to PAT_W bits, shifts it out MSB-first on one wire, and repeats it a programmed number of times with a fixed idle gap between copies. It sits in the test/stimulus layer and drives a detector's input i directly.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of len port; must satisfy 2^LEN_W > PAT_W
CNT_W, 4, width of reps port and repeat counter
GAP, 2, idle cycles between consecutive copies; 0 means back-to-back
IDLE_BIT, 1'b0, value driven on o whenever o_valid=0

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
start  input  1  request to begin transmission; sampled only in IDLE
pattern  input  PAT_W  bits to send; bit len-1 goes first, bit 0 last
len  input  LEN_W  number of pattern bits to send, legal 1..PAT_W
reps  input  CNT_W  number of copies to send, legal 1..2^CNT_W-1
abort  input  1  synchronous cancel of an active transmission
o  output  1  serial data bit (feeds detector input i)
o_valid  output  1  high in each cycle o carries a pattern bit
busy  output  1  high from the cycle after start is accepted until done/abort
done  output  1  one-cycle pulse after last bit of last copy
err  output  1  one-cycle pulse when start is rejected

Behaviour:
- All outputs registered. While reset=0: state=IDLE, o=IDLE_BIT, o_valid=0, busy=0, done=0, err=0, shift/len/rep/gap counters cleared. Reset acts immediately, including mid-transmission; no done is produced for a killed transmission.
- States: IDLE, SEND, GAP, DONE.
- IDLE: if start=1 and len in 1..PAT_W and reps>=1 -> latch pattern, len, reps; go to SEND. The first bit (pattern[len-1]) is on o with o_valid=1 and busy=1 in the cycle after the accepting edge (latency 1). If start=1 with len=0, len>PAT_W, or reps=0 -> err=1 for one cycle, stay IDLE.
- SEND: each cycle emits the next bit, descending from bit len-1 to bit 0; exactly len cycles per copy with o_valid=1. After bit 0: if copies remaining >1 -> GAP (if GAP>0) or directly to bit len-1 of the next copy (if GAP=0, no bubble). If this was the last copy -> DONE.
- GAP: exactly GAP cycles with o=IDLE_BIT, o_valid=0, busy=1; then SEND restarts from latched pattern bit len-1.
- DONE: one cycle with done=1, busy=0, o_valid=0, o=IDLE_BIT; then IDLE. start in the DONE cycle is ignored; start is accepted from the IDLE cycle after it.
- start while busy (SEND/GAP/DONE) is ignored, with no err. Changes to pattern/len/reps while busy have no effect.
- abort=1 in SEND or GAP: at the next edge go to IDLE, o_valid=0, busy=0, o=IDLE_BIT, no done. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Copy counter counts down from reps and never wraps. Bits of pattern above len-1 are never transmitted.

Test Plan:
1. Release reset; pattern=8'b0000_0110, len=4, reps=1, pulse start -> o=0,1,1,0 on 4 consecutive cycles with o_valid=1 starting one cycle after start; done=1 on the 5th cycle; busy low again at the same time.
2. Same pattern, reps=3, GAP=2 -> 0110, 2 cycles o_valid=0/o=IDLE_BIT, 0110, gap, 0110, done; total 4*3+2*2=16 busy cycles; detector for "0110" sees 3 hits.
3. len=0, then len=9 (PAT_W=8), then reps=0 with start -> err pulses once each, o_valid never rises, busy stays 0.
4. Mid-copy: assert abort on the 3rd bit of copy 2 of 3 -> next cycle o_valid=0, busy=0, no done; new start is accepted on the following cycle.
5. Drive reset=0 asynchronously mid-SEND (between clock edges) -> o_valid/busy fall immediately without an edge; after release, IDLE with all outputs zero.
6. GAP=0 build, pattern=8'b1010_1011, len=8, reps=2 -> 16 contiguous o_valid cycles 10101011 10101011; start pulsed during transmission is ignored (no err, no restart).

Source files
------------

// File: rtl/sequence_generator_io.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, repeated
// a programmed number of times with a fixed idle gap between copies.
module sequence_generator_io #(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = 4,
  parameter int   CNT_W    = 4,
  parameter int   GAP      = 2,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [LEN_W:0]   LEN_MAX  = (LEN_W+1)'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       gap_q, gap_d;
  logic             o_d, valid_d, busy_d, done_d, err_d;

  logic [PAT_W-1:0] new_shift, cur_shift, restart_shift;
  logic             accept;

  // idx_q is the bit index currently on o, so the next bit is idx_q-1
  assign new_shift     = pattern >> (len - LEN_ONE);
  assign cur_shift     = pat_q >> (idx_q - LEN_ONE);
  assign restart_shift = pat_q >> (len_q - LEN_ONE);

  assign accept = start && (len != '0) && ({1'b0, len} <= LEN_MAX) && (reps != '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    o_d     = IDLE_BIT;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEND;
          pat_d   = pattern;
          len_d   = len;
          rep_d   = reps;
          idx_d   = len - LEN_ONE;
          o_d     = new_shift[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - LEN_ONE;
          o_d     = cur_shift[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rep_q > CNT_ONE) begin
          rep_d  = rep_q - CNT_ONE;
          busy_d = 1'b1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end else begin
            idx_d   = len_q - LEN_ONE;
            o_d     = restart_shift[0];
            valid_d = 1'b1;
          end
        end else begin
          state_d = S_DONE;
          rep_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q == 8'd0) begin
          state_d = S_SEND;
          idx_d   = len_q - LEN_ONE;
          o_d     = restart_shift[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gap_d  = gap_q - 8'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      o       <= IDLE_BIT;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      o       <= o_d;
      o_valid <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_sequence_generator_io.sv
// Bench for sequence_generator_io: a GAP=2 and a GAP=0 instance share stimulus
// and are compared cycle by cycle against an expected-stream model.
module tb_sequence_generator_io;

  localparam int   PAT_W    = 8;
  localparam int   LEN_W    = 4;
  localparam int   CNT_W    = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [CNT_W-1:0] reps = '0;

  logic o2, v2, b2, d2, e2;
  logic o0, v0, b0, d0, e0;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle word is {o_valid, o, busy, done}
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  localparam logic [3:0] IDLE_E = {1'b0, IDLE_BIT, 1'b0, 1'b0};

  sequence_generator_io #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(2), .IDLE_BIT(IDLE_BIT)) dut (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .o(o2), .o_valid(v2), .busy(b2), .done(d2), .err(e2)
  );

  sequence_generator_io #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(0), .IDLE_BIT(IDLE_BIT)) dut0 (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .o(o0), .o_valid(v0), .busy(b0), .done(d0), .err(e0)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Expected stream: copies of bits len-1..0, gap cycles between copies,
  // one done cycle; an abort seen while busy cuts everything after it.
  task automatic buildModel(input int gap, input logic [PAT_W-1:0] p, input int l, input int r,
                            input int abortAt, output logic [3:0] q[$]);
    q = {};
    for (int c = 0; c < r; c++) begin
      for (int b = l - 1; b >= 0; b--) q.push_back({1'b1, p[b], 1'b1, 1'b0});
      if (c < r - 1) for (int g = 0; g < gap; g++) q.push_back({1'b0, IDLE_BIT, 1'b1, 1'b0});
    end
    q.push_back({1'b0, IDLE_BIT, 1'b0, 1'b1});
    if (abortAt >= 0 && abortAt < q.size())
      if (q[abortAt][1]) q = q[0:abortAt];
  endtask

  task automatic applyStimulus(input string tag, input logic [PAT_W-1:0] p, input int l,
                               input int r, input int abortAt);
    int n;
    buildModel(2, p, l, r, abortAt, qa);
    buildModel(0, p, l, r, abortAt, qb);
    n = ((qa.size() > qb.size()) ? qa.size() : qb.size()) + 1;
    @(posedge clock); #1;
    start = 1'b1; pattern = p; len = LEN_W'(l); reps = CNT_W'(r); abort = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("%s gap2 k=%0d", tag, k), {v2, o2, b2, d2}, (k < qa.size()) ? qa[k] : IDLE_E);
      checkOutput($sformatf("%s gap0 k=%0d", tag, k), {v0, o0, b0, d0}, (k < qb.size()) ? qb[k] : IDLE_E);
      checkOutput($sformatf("%s err k=%0d", tag, k), {2'b00, e2, e0}, 4'b0000);
      start   = 1'b0;
      abort   = (k == abortAt);
      pattern = PAT_W'($urandom);
      len     = LEN_W'($urandom);
      reps    = CNT_W'($urandom);
      if (k == 1 && l >= 3 && (abortAt < 0 || abortAt >= 2)) start = 1'b1;
    end
    abort = 1'b0;
  endtask

  task automatic applyReject(input string tag, input int l, input int r);
    @(posedge clock); #1;
    start = 1'b1; len = LEN_W'(l); reps = CNT_W'(r); pattern = 8'hFF;
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput({tag, " pulse"}, {v2, b2, e2, e0}, 4'b0011);
    checkOutput({tag, " pulse0"}, {v0, b0, d2, d0}, 4'b0000);
    @(posedge clock); #1;
    checkOutput({tag, " after"}, {v2, b2, e2, e0}, 4'b0000);
  endtask

  initial begin
    #12;
    checkOutput("reset gap2", {v2, o2, b2, d2}, IDLE_E);
    checkOutput("reset gap0", {v0, o0, b0, e2}, IDLE_E);
    @(negedge clock); reset = 1'b1;

    applyStimulus("single", 8'b0000_0110, 4, 1, -1);
    applyStimulus("repeat3", 8'b0000_0110, 4, 3, -1);

    applyReject("len0", 0, 1);
    applyReject("len9", 9, 1);
    applyReject("reps0", 4, 0);

    applyStimulus("abort", 8'b0000_0110, 4, 3, 8);
    applyStimulus("postabort", 8'b1100_0101, 5, 1, -1);
    applyStimulus("fullwidth", 8'b1010_1011, 8, 2, -1);
    applyStimulus("upperbits", 8'b1111_0010, 3, 2, -1);
    applyStimulus("maxreps", 8'b0000_0001, 1, 15, -1);

    // Asynchronous reset between edges in the middle of a copy
    @(posedge clock); #1;
    start = 1'b1; pattern = 8'b1110_0111; len = 4'd8; reps = 4'd2;
    repeat (3) @(posedge clock);
    #1; start = 1'b0;
    checkOutput("prereset busy", {v2, b2, v0, b0}, 4'b1111);
    #2; reset = 1'b0;
    #1;
    checkOutput("async gap2", {v2, o2, b2, d2}, IDLE_E);
    checkOutput("async gap0", {v0, o0, b0, d0}, IDLE_E);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("postreset", {v2, b2, v0, b0}, 4'b0000);
    checkOutput("postreset flags", {d2, d0, e2, e0}, 4'b0000);

    for (int t = 0; t < 20; t++) begin
      int l, r, ab;
      l  = $urandom_range(1, PAT_W);
      r  = $urandom_range(1, 4);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, l * r + 2 * r) : -1;
      applyStimulus($sformatf("rand%0d", t), PAT_W'($urandom), l, r, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
